opponent_punch_scheduler: RTL and testbench
===========================================

// Module: opponent_punch_scheduler
// PURPOSE
//  Sequences the opponent's attacks using the 8-bit LFSR random-bit generator.
//  Supplies the LFSR seed counter and gates its enable. Collects random bits
//  into a wait delay and a punch side, then drives windup and strike timing.
//  Sits between the LFSR and the opponent sprite/collision logic; one attack in flight at a time.
// PARAMETERS
//  DELAY_BITS       4   random bits gathered per attack for the wait delay (1..8)
//  MIN_WAIT         16  base idle cycles before windup (1..255)
//  WINDUP_CYCLES    8   cycles windup is shown before the strike (1..255)
//  COOLDOWN_CYCLES  12  cycles after a resolved strike before the next gather (1..255)
// PORTS
//  clock         in   1  system clock, all logic on rising edge
//  reset         in   1  synchronous, active-high reset
//  game_active   in   1  level; high while a round is running
//  random_bit    in   1  LFSR output bit, valid every cycle
//  lfsr_enable   out  1  LFSR shift enable
//  seed_counter  out  8  free-running counter, feeds the LFSR counter_val seed input
//  windup        out  1  opponent winding up (telegraph)
//  punch_side    out  1  0=left, 1=right; stable from windup through strike
//  punch_valid   out  1  strike request to collision logic
//  punch_ack     in   1  collision logic accepts the strike (same-cycle handshake)
//  punch_hit     in   1  sampled with punch_ack: 1=player hit, 0=dodged/blocked
//  hit_count     out  8  strikes that landed, wraps 255->0
//  miss_count    out  8  strikes dodged, wraps 255->0
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; seed_counter=0; delay_reg=0; all counters=0.
//  seed_counter:
//   - increments every cycle in every state except reset; wraps 255->0.
//  FSM, one state per clock; outputs are registered and decoded from state:
//   IDLE     lfsr_enable=0. If game_active=1, go to SEED.
//   SEED     1 cycle, lfsr_enable=0; the LFSR latches its seed. Go to GATHER.
//   GATHER   lfsr_enable=1 for DELAY_BITS+1 cycles.
//            - First DELAY_BITS cycles: delay_reg <= {delay_reg, random_bit}, so the first bit lands at the MSB.
//            - Last cycle: punch_side <= random_bit.
//            - Then go to WAIT and load wait_cnt = MIN_WAIT + delay_reg (9-bit, no overflow).
//   WAIT     lfsr_enable=0; wait_cnt decrements once per cycle.
//            - Go to WINDUP on the cycle wait_cnt==1, so WAIT lasts exactly MIN_WAIT+delay_reg cycles.
//   WINDUP   windup=1 for exactly WINDUP_CYCLES cycles, then go to STRIKE.
//   STRIKE   punch_valid=1 and windup=0; held until punch_ack=1.
//            - On ack: punch_valid drops the next cycle.
//            - Increment hit_count if punch_hit=1, else miss_count.
//            - Go to COOLDOWN.
//            - No timeout: valid never drops without an ack.
//   COOLDOWN COOLDOWN_CYCLES cycles.
//            - Then go to GATHER if game_active=1, else IDLE.
//            - Re-seeding happens only from IDLE.
//  game_active=0, abort rule:
//   - In SEED/GATHER/WAIT/WINDUP/COOLDOWN: next state is IDLE; windup, punch_valid and lfsr_enable drop that cycle.
//   - In STRIKE: the handshake completes first, then the FSM goes straight to IDLE, skipping cooldown.
//  Other rules:
//   - punch_ack outside STRIKE is ignored; counters unchanged.
//   - punch_side holds its last value in IDLE.
//   - reset asserted in any state, including mid-strike, wins: everything returns to reset values next edge.
//   - Counters hit_count/miss_count are cleared only by reset.
// TESTING
//  T1 reset=1 2 cycles, random_bit=0, game_active=1 -> after SEED (1 cycle) and GATHER (5 cycles):
//     WAIT 16 cycles, windup high 8 cycles, punch_side=0, punch_valid rises next.
//  T2 random_bit=1 constant -> delay_reg=4'hF, punch_side=1, WAIT lasts 31 cycles;
//     lfsr_enable high exactly 5 cycles per attack.
//  T3 STRIKE with punch_ack low 10 cycles then ack with punch_hit=1 -> valid held 11 cycles;
//     hit_count 0->1, miss_count 0; COOLDOWN 12 cycles; GATHER re-entered.
//  T4 drop game_active mid-WAIT -> IDLE next cycle, no windup/valid.
//     Drop game_active mid-STRIKE -> valid held until ack, then IDLE directly.
//  T5 256 acked misses -> miss_count wraps to 0. Reset pulse mid-WINDUP -> all outputs 0,
//     seed_counter=0 next edge.
//  T6 seed_counter free-runs 0..255..0 across IDLE/WAIT;
//     two rounds started at different counter values present different seed_counter values in SEED.

Source files
------------

// File: rtl/opponent_punch_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : opponent_punch_scheduler
// Description : Opponent attack sequencer. Gathers LFSR bits into a wait
//               delay and a punch side, then drives windup and strike timing.
// Revision    : 1.0 - initial release
// ============================================================================
module opponent_punch_scheduler #(
    parameter int DELAY_BITS      = 4,
    parameter int MIN_WAIT        = 16,
    parameter int WINDUP_CYCLES   = 8,
    parameter int COOLDOWN_CYCLES = 12
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       game_active,
    input  logic       random_bit,
    output logic       lfsr_enable,
    output logic [7:0] seed_counter,
    output logic       windup,
    output logic       punch_side,
    output logic       punch_valid,
    input  logic       punch_ack,
    input  logic       punch_hit,
    output logic [7:0] hit_count,
    output logic [7:0] miss_count
);

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_SEED     = 3'd1;
    localparam logic [2:0] c_ST_GATHER   = 3'd2;
    localparam logic [2:0] c_ST_WAIT     = 3'd3;
    localparam logic [2:0] c_ST_WINDUP   = 3'd4;
    localparam logic [2:0] c_ST_STRIKE   = 3'd5;
    localparam logic [2:0] c_ST_COOLDOWN = 3'd6;

    localparam logic [8:0] c_GATHER_LOAD = 9'(DELAY_BITS);
    localparam logic [8:0] c_WINDUP_LOAD = 9'(WINDUP_CYCLES - 1);
    localparam logic [8:0] c_COOL_LOAD   = 9'(COOLDOWN_CYCLES - 1);
    localparam logic [8:0] c_MIN_WAIT    = 9'(MIN_WAIT);

    logic [2:0]            r_state;
    logic [2:0]            w_state_next;
    logic [8:0]            r_cnt;
    logic [8:0]            w_cnt_next;
    logic [DELAY_BITS-1:0] r_delay;
    logic [DELAY_BITS:0]   w_delay_shift;

    // Shared down-counter: GATHER/WINDUP/COOLDOWN exit at 0, WAIT exits at 1.
    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_delay_shift = {r_delay, random_bit};
        case (r_state)
            c_ST_IDLE: begin
                if (game_active) w_state_next = c_ST_SEED;
            end
            c_ST_SEED: begin
                if (!game_active) begin
                    w_state_next = c_ST_IDLE;
                end else begin
                    w_state_next = c_ST_GATHER;
                    w_cnt_next   = c_GATHER_LOAD;
                end
            end
            c_ST_GATHER: begin
                if (!game_active) begin
                    w_state_next = c_ST_IDLE;
                end else if (r_cnt == 9'd0) begin
                    w_state_next = c_ST_WAIT;
                    w_cnt_next   = c_MIN_WAIT + 9'(r_delay);
                end else begin
                    w_cnt_next = r_cnt - 9'd1;
                end
            end
            c_ST_WAIT: begin
                if (!game_active) begin
                    w_state_next = c_ST_IDLE;
                end else if (r_cnt == 9'd1) begin
                    w_state_next = c_ST_WINDUP;
                    w_cnt_next   = c_WINDUP_LOAD;
                end else begin
                    w_cnt_next = r_cnt - 9'd1;
                end
            end
            c_ST_WINDUP: begin
                if (!game_active) begin
                    w_state_next = c_ST_IDLE;
                end else if (r_cnt == 9'd0) begin
                    w_state_next = c_ST_STRIKE;
                end else begin
                    w_cnt_next = r_cnt - 9'd1;
                end
            end
            c_ST_STRIKE: begin
                // A strike is never abandoned; game_active only picks the exit.
                if (punch_ack) begin
                    w_state_next = game_active ? c_ST_COOLDOWN : c_ST_IDLE;
                    w_cnt_next   = c_COOL_LOAD;
                end
            end
            c_ST_COOLDOWN: begin
                if (!game_active) begin
                    w_state_next = c_ST_IDLE;
                end else if (r_cnt == 9'd0) begin
                    w_state_next = c_ST_GATHER;
                    w_cnt_next   = c_GATHER_LOAD;
                end else begin
                    w_cnt_next = r_cnt - 9'd1;
                end
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_cnt        <= 9'd0;
            r_delay      <= '0;
            seed_counter <= 8'd0;
            lfsr_enable  <= 1'b0;
            windup       <= 1'b0;
            punch_side   <= 1'b0;
            punch_valid  <= 1'b0;
            hit_count    <= 8'd0;
            miss_count   <= 8'd0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            seed_counter <= seed_counter + 8'd1;
            lfsr_enable  <= (w_state_next == c_ST_GATHER);
            windup       <= (w_state_next == c_ST_WINDUP);
            punch_valid  <= (w_state_next == c_ST_STRIKE);
            if (r_state == c_ST_GATHER && game_active) begin
                if (r_cnt != 9'd0) begin
                    r_delay <= w_delay_shift[DELAY_BITS-1:0];
                end else begin
                    punch_side <= random_bit;
                end
            end
            if (r_state == c_ST_STRIKE && punch_ack) begin
                if (punch_hit) begin
                    hit_count <= hit_count + 8'd1;
                end else begin
                    miss_count <= miss_count + 8'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_opponent_punch_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_opponent_punch_scheduler
// Description : Randomized scoreboard bench for opponent_punch_scheduler;
//               expected attack timelines are derived from the timing rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_opponent_punch_scheduler;

    localparam int D    = 4;
    localparam int MINW = 16;
    localparam int WU   = 8;
    localparam int CD   = 12;

    logic       clock = 1'b0;
    logic       reset;
    logic       game_active;
    logic       random_bit;
    logic       lfsr_enable;
    logic [7:0] seed_counter;
    logic       windup;
    logic       punch_side;
    logic       punch_valid;
    logic       punch_ack;
    logic       punch_hit;
    logic [7:0] hit_count;
    logic [7:0] miss_count;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic r_rst_at_edge = 1'b0;

    typedef struct {
        int         tg;
        int         en;
        int         tw;
        int         wu;
        int         tv;
        int         tend;
        logic       side;
        logic [7:0] hit;
        logic [7:0] miss;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] exp_hit  = 8'd0;
    logic [7:0] exp_miss = 8'd0;

    opponent_punch_scheduler #(
        .DELAY_BITS(D), .MIN_WAIT(MINW), .WINDUP_CYCLES(WU), .COOLDOWN_CYCLES(CD)
    ) dut (
        .clock(clock), .reset(reset), .game_active(game_active),
        .random_bit(random_bit), .lfsr_enable(lfsr_enable),
        .seed_counter(seed_counter), .windup(windup), .punch_side(punch_side),
        .punch_valid(punch_valid), .punch_ack(punch_ack), .punch_hit(punch_hit),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc           <= cyc + 1;
        r_rst_at_edge <= reset;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d cycle=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clock);
    endtask

    task automatic chk_reset_state();
        chk("rst_lfsr_enable", lfsr_enable, 0);
        chk("rst_seed_counter", seed_counter, 0);
        chk("rst_windup", windup, 0);
        chk("rst_punch_side", punch_side, 0);
        chk("rst_punch_valid", punch_valid, 0);
        chk("rst_hit_count", hit_count, 0);
        chk("rst_miss_count", miss_count, 0);
    endtask

    // Monitor: seed_counter model every cycle, attack timing on each strike.
    initial begin
        automatic logic       seeded = 1'b0;
        automatic logic       pv = 1'b0, pw = 1'b0, pe = 1'b0, have = 1'b0;
        automatic logic [7:0] es = 8'd0;
        automatic int         tg = 0, en = 0, tw = -1, wu = 0;
        exp_t                 cur;
        forever begin
            @(negedge clock);
            if (r_rst_at_edge) begin
                seeded = 1'b1; es = 8'd0;
                pv = 1'b0; pw = 1'b0; pe = 1'b0; have = 1'b0;
            end else if (seeded) begin
                es++;
                chk("seed_counter", seed_counter, es);
                if (lfsr_enable && !pe) begin tg = cyc; en = 0; tw = -1; wu = 0; end
                if (lfsr_enable) en++;
                if (windup && !pw) tw = cyc;
                if (windup) wu++;
                if (punch_valid && !pv) begin
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL strike_expected actual=strike required=none cycle=%0d", cyc);
                    end else begin
                        cur  = sb.pop_front();
                        have = 1'b1;
                        chk("gather_start", tg, cur.tg);
                        chk("lfsr_enable_len", en, cur.en);
                        chk("windup_start", tw, cur.tw);
                        chk("windup_len", wu, cur.wu);
                        chk("strike_start", cyc, cur.tv);
                        chk("punch_side", punch_side, cur.side);
                    end
                end
                if (!punch_valid && pv && have) begin
                    chk("strike_end", cyc, cur.tend);
                    chk("hit_count", hit_count, cur.hit);
                    chk("miss_count", miss_count, cur.miss);
                    have = 1'b0;
                end
                pe = lfsr_enable; pw = windup; pv = punch_valid;
            end
        end
    end

    // pat: 0 all-zero bits, 1 all-one bits, else random.
    // mode: 0 normal, 1 abort in WAIT, 2 drop in STRIKE, 3 drop in COOLDOWN, 4 reset in WINDUP.
    task automatic attack(input int g, input int pat, input int ad_in, input int hit_in,
                          input int mode, output int next_g);
        logic [D-1:0] dly;
        logic         sd, h;
        int           w, tw, tv, ad, tend;
        exp_t         e;
        if (pat == 0)      begin dly = '0; sd = 1'b0; end
        else if (pat == 1) begin dly = '1; sd = 1'b1; end
        else               begin dly = D'($urandom); sd = 1'($urandom); end
        ad = (ad_in < 0) ? int'($urandom_range(0, 6)) : ad_in;
        h  = (hit_in < 0) ? 1'($urandom) : 1'(hit_in);
        for (int i = 0; i <= D; i++) begin
            wait_until(g + i);
            punch_ack  = 1'b0;
            random_bit = (i < D) ? dly[D-1-i] : sd;
        end
        w    = MINW + int'(dly);
        tw   = g + D + 1 + w;
        tv   = tw + WU;
        tend = tv + ad + 1;
        wait_until(g + D + 1);
        random_bit = ~sd;
        punch_ack  = 1'($urandom);
        punch_hit  = 1'($urandom);
        next_g     = -1;
        if (mode == 1) begin
            wait_until(g + D + 1 + int'($urandom_range(0, w - 1)));
            game_active = 1'b0;
            punch_ack   = 1'b0;
            repeat (40) begin
                @(negedge clock);
                chk("abort_windup", windup, 0);
                chk("abort_valid", punch_valid, 0);
                chk("abort_lfsr_enable", lfsr_enable, 0);
            end
        end else if (mode == 4) begin
            wait_until(tw + int'($urandom_range(0, WU - 1)));
            reset     = 1'b1;
            punch_ack = 1'b0;
            @(negedge clock);
            chk_reset_state();
            reset    = 1'b0;
            exp_hit  = 8'd0;
            exp_miss = 8'd0;
            next_g   = cyc + 2;
        end else begin
            if (h) exp_hit++;
            else   exp_miss++;
            e.tg = g; e.en = D + 1; e.tw = tw; e.wu = WU; e.tv = tv; e.tend = tend;
            e.side = sd; e.hit = exp_hit; e.miss = exp_miss;
            sb.push_back(e);
            wait_until(tv);
            punch_ack = 1'b0;
            if (mode == 2) game_active = 1'b0;
            wait_until(tv + ad);
            punch_ack = 1'b1;
            punch_hit = h;
            wait_until(tend);
            punch_ack = 1'($urandom);
            punch_hit = 1'($urandom);
            if (mode == 3) begin
                wait_until(tend + int'($urandom_range(0, CD - 1)));
                game_active = 1'b0;
                @(negedge clock);
            end else if (mode != 2) begin
                next_g = tend + CD;
            end
        end
    endtask

    task automatic start_round(output int g);
        repeat ($urandom_range(1, 15)) @(negedge clock);
        game_active = 1'b1;
        g = cyc + 2;
    endtask

    initial begin
        int g;
        int modes[6] = '{0, 0, 1, 2, 3, 0};
        reset = 1'b1; game_active = 1'b1; random_bit = 1'b0;
        punch_ack = 1'b0; punch_hit = 1'b0;
        wait_until(2);
        chk_reset_state();
        reset = 1'b0;
        g = cyc + 2;
        attack(g, 0, 2, 0, 0, g);
        attack(g, 1, 3, 1, 0, g);
        attack(g, 2, 10, 1, 0, g);
        for (int n = 0; n < 24; n++) begin
            attack(g, 2, -1, -1, modes[$urandom_range(0, 5)], g);
            if (g < 0) start_round(g);
        end
        attack(g, 2, -1, -1, 4, g);
        for (int n = 0; n < 260; n++) attack(g, 2, 0, 0, 0, g);
        game_active = 1'b0;
        repeat (30) @(negedge clock);
        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
